// File: rtl/alu_op_sequencer_if.sv
// Bus between the ALU op sequencer and its environment: operand/range request,
// ALU drive/return, and the captured result stream.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 4,
    parameter int SIG_W = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [SEL_W-1:0] first_sel;
    logic [SEL_W-1:0] last_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic [SEL_W-1:0] res_sel;
    logic [WIDTH-1:0] res_data;
    logic [SIG_W-1:0] signature;
    logic             busy;
    logic             done;

    modport master (
        input  start, a_in, b_in, first_sel, last_sel, alu_result,
        output alu_a, alu_b, alu_sel, alu_en, res_valid, res_sel, res_data,
               signature, busy, done
    );

    modport slave (
        output start, a_in, b_in, first_sel, last_sel, alu_result,
        input  alu_a, alu_b, alu_sel, alu_en, res_valid, res_sel, res_data,
               signature, busy, done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sweeps the ALU select through a latched opcode range, holding each opcode
// HOLD cycles, streaming captured results and folding them into a signature.
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 4,
    parameter int HOLD  = 4,
    parameter int SIG_W = 8
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [SEL_W-1:0] last_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            last_lat      <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.alu_en    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_sel   <= '0;
            bus.res_data  <= '0;
            bus.signature <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            bus.done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Operand registers double as the latch for a_in/b_in.
                    if (bus.start) begin
                        bus.alu_a     <= bus.a_in;
                        bus.alu_b     <= bus.b_in;
                        bus.alu_sel   <= bus.first_sel;
                        last_lat      <= bus.last_sel;
                        bus.signature <= '0;
                        bus.busy      <= 1'b1;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    hold_cnt   <= '0;
                    bus.alu_en <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        bus.res_data  <= bus.alu_result;
                        bus.res_sel   <= bus.alu_sel;
                        bus.res_valid <= 1'b1;
                        bus.signature <= {bus.signature[SIG_W-2:0], bus.signature[SIG_W-1]}
                                         ^ SIG_W'(bus.alu_result);
                        if (bus.alu_sel == last_lat) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.alu_sel <= bus.alu_sel + SEL_W'(1);
                            hold_cnt    <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                DONE: begin
                    hold_cnt   <= '0;
                    bus.alu_en <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, result scoreboard, vector table
// and hand sequences for ignored start, mid-sweep reset and a HOLD=1 build.
module tb_alu_op_sequencer;
    localparam int WIDTH = 4;
    localparam int SEL_W = 4;
    localparam int SIG_W = 8;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .SIG_W(SIG_W)) bus0 ();
    alu_op_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .SIG_W(SIG_W)) bus1 ();

    alu_op_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .HOLD(HOLD), .SIG_W(SIG_W)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    alu_op_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .HOLD(1), .SIG_W(SIG_W)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] alu_fn(int m, logic [WIDTH-1:0] a,
                                                logic [WIDTH-1:0] b, logic [SEL_W-1:0] s);
        case (m)
            0:       return a + b;
            1:       return 4'hF;
            default: return (a ^ s) + b;
        endcase
    endfunction

    always_comb bus0.alu_result = alu_fn(mode, bus0.alu_a, bus0.alu_b, bus0.alu_sel);
    always_comb bus1.alu_result = alu_fn(2, bus1.alu_a, bus1.alu_b, bus1.alu_sel);

    task automatic chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
        logic [SIG_W-1:0] sig;
        logic [WIDTH-1:0] a;
        int               cyc;
        bit               last;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   pulse_cnt = 0;
    int   done_cnt  = 0;

    always @(negedge clk) begin
        if (!rst && bus0.done) done_cnt++;
        if (!rst && bus0.res_valid) begin
            pulse_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_res_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("res_sel", int'(bus0.res_sel), int'(mon_e.sel));
                chk("res_data", int'(bus0.res_data), int'(mon_e.data));
                chk("signature", int'(bus0.signature), int'(mon_e.sig));
                chk("alu_a_stable", int'(bus0.alu_a), int'(mon_e.a));
                chk("capture_cycle", cyc, mon_e.cyc);
                chk("done_with_last", int'(bus0.done), int'(mon_e.last));
            end
        end
    end

    // Expected stream for one sweep, timed from the start edge t0.
    task automatic push_exp(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [SEL_W-1:0] f,
                            logic [SEL_W-1:0] l, int m, int t0, output int n);
        logic [SEL_W-1:0] diff;
        logic [SEL_W-1:0] s;
        logic [SIG_W-1:0] sig;
        exp_t             e;
        diff = l - f;
        n    = int'(diff) + 1;
        s    = f;
        sig  = '0;
        for (int k = 1; k <= n; k++) begin
            e.data = alu_fn(m, a, b, s);
            sig    = {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(e.data);
            e.sel  = s;
            e.sig  = sig;
            e.a    = a;
            e.cyc  = t0 + 1 + HOLD * k;
            e.last = (k == n);
            sbq.push_back(e);
            s = s + 1'b1;
        end
    endtask

    task automatic run_sweep(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [SEL_W-1:0] f,
                             logic [SEL_W-1:0] l, int m, bit poke, int exp_n);
        int t0, n, p0, d0;
        bit seen;
        @(negedge clk);
        mode = m;
        bus0.a_in = a; bus0.b_in = b; bus0.first_sel = f; bus0.last_sel = l;
        bus0.start = 1'b1;
        p0 = pulse_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        t0 = cyc;
        push_exp(a, b, f, l, m, t0, n);
        @(negedge clk);
        chk("setup_alu_en", int'(bus0.alu_en), 0);
        chk("setup_busy", int'(bus0.busy), 1);
        chk("setup_alu_a", int'(bus0.alu_a), int'(a));
        chk("setup_alu_b", int'(bus0.alu_b), int'(b));
        @(negedge clk);
        chk("run_alu_en", int'(bus0.alu_en), 1);
        seen = 0;
        for (int i = 0; i < HOLD * 16 + 20 && !seen; i++) begin
            if (bus0.done) begin
                seen = 1;
            end else begin
                if (poke && i == 8) begin
                    bus0.start = 1'b1;
                    bus0.a_in  = ~a;
                end else begin
                    bus0.start = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus0.start = 1'b0;
        chk("sweep_completed", int'(seen), 1);
        chk("done_cycle", cyc, t0 + 1 + HOLD * n);
        chk("done_alu_en", int'(bus0.alu_en), 1);
        if (poke) begin
            bus0.start = 1'b1;
            bus0.a_in  = ~a;
        end
        @(negedge clk);
        bus0.start = 1'b0;
        chk("busy_after_done", int'(bus0.busy), 0);
        chk("alu_en_after_done", int'(bus0.alu_en), 0);
        chk("done_after_done", int'(bus0.done), 0);
        chk("pulse_count", pulse_cnt - p0, exp_n);
        chk("done_count", done_cnt - d0, 1);
        chk("scoreboard_drained", sbq.size(), 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] f;
        logic [SEL_W-1:0] l;
        int               m;
        bit               poke;
        int               n;
    } vec_t;

    vec_t vt[6];

    initial begin
        int cnt, t0, c, n5;
        bit hit;
        vt[0] = '{4'b0010, 4'b0100, 4'd0,  4'd15, 0, 1'b0, 16};
        vt[1] = '{4'h3,    4'h5,    4'd3,  4'd4,  1, 1'b0, 2};
        vt[2] = '{4'h6,    4'h9,    4'd14, 4'd1,  2, 1'b0, 4};
        vt[3] = '{4'hA,    4'h1,    4'd7,  4'd7,  2, 1'b0, 1};
        vt[4] = '{4'h5,    4'hC,    4'd2,  4'd9,  2, 1'b1, 8};
        vt[5] = '{4'hF,    4'hE,    4'd15, 4'd0,  2, 1'b0, 2};

        bus0.start = 1'b0; bus0.a_in = '0; bus0.b_in = '0; bus0.first_sel = '0; bus0.last_sel = '0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.first_sel = '0; bus1.last_sel = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(bus0.busy), 0);
        chk("reset_alu_en", int'(bus0.alu_en), 0);
        chk("reset_res_valid", int'(bus0.res_valid), 0);
        chk("reset_signature", int'(bus0.signature), 0);
        chk("reset_alu_sel", int'(bus0.alu_sel), 0);
        chk("reset_h1_busy", int'(bus1.busy), 0);

        for (int v = 0; v < 6; v++) begin
            run_sweep(vt[v].a, vt[v].b, vt[v].f, vt[v].l, vt[v].m, vt[v].poke, vt[v].n);
            if (v == 0) begin
                chk("hold_res_data", int'(bus0.res_data), 6);
                chk("hold_res_sel", int'(bus0.res_sel), 15);
            end
            if (v == 1) chk("const_signature", int'(bus0.signature), 8'h11);
            if (v == 4) chk("poke_alu_a_kept", int'(bus0.alu_a), 5);
        end

        // Mid-sweep reset after the 5th capture.
        @(negedge clk);
        mode = 2;
        bus0.a_in = 4'h9; bus0.b_in = 4'h3; bus0.first_sel = 4'd0; bus0.last_sel = 4'd15;
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        t0 = cyc;
        push_exp(4'h9, 4'h3, 4'd0, 4'd15, 2, t0, n5);
        cnt = 0;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (bus0.res_valid) cnt++;
            if (cnt == 5) hit = 1;
        end
        chk("reached_fifth_capture", int'(hit), 1);
        c = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("abort_busy", int'(bus0.busy), 0);
        chk("abort_alu_en", int'(bus0.alu_en), 0);
        chk("abort_res_valid", int'(bus0.res_valid), 0);
        chk("abort_done", int'(bus0.done), 0);
        chk("abort_alu_a", int'(bus0.alu_a), 0);
        chk("abort_alu_sel", int'(bus0.alu_sel), 0);
        chk("abort_res_data", int'(bus0.res_data), 0);
        chk("abort_res_sel", int'(bus0.res_sel), 0);
        chk("abort_signature", int'(bus0.signature), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - c, 0);
        run_sweep(4'h9, 4'h3, 4'd0, 4'd15, 2, 1'b0, 16);

        // HOLD=1 build: one capture per cycle.
        @(negedge clk);
        bus1.a_in = 4'h7; bus1.b_in = 4'h2; bus1.first_sel = 4'd0; bus1.last_sel = 4'd15;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            logic [SEL_W-1:0] es;
            @(negedge clk);
            c  = cyc - t0;
            es = SEL_W'(c - 2);
            chk("h1_res_valid", int'(bus1.res_valid), int'(c >= 2 && c <= 17));
            chk("h1_done", int'(bus1.done), int'(c == 17));
            if (c >= 2 && c <= 17) begin
                chk("h1_res_sel", int'(bus1.res_sel), c - 2);
                chk("h1_res_data", int'(bus1.res_data), int'(alu_fn(2, 4'h7, 4'h2, es)));
            end
        end
        chk("h1_idle_after", int'(bus1.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Synthesizable initiator for the 4-bit ALU. Latches one operand pair and an opcode range, then sweeps the ALU select input through that range.
- Holds each opcode for a fixed number of cycles, captures the ALU result and streams each (sel, result) pair out.
- Folds every captured result into a running signature.
- Replaces hand-written stimulus sequencing; used for on-chip self-test of the ALU and for bench regression.

Parameters:
- WIDTH, 4: operand and result width.
- SEL_W, 4: opcode width; the sweep wraps modulo 2**SEL_W.
- HOLD, 4: cycles each opcode is held before its result is captured; legal range 1..255.
- SIG_W, 8: signature width; must be ≥ WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- a_in  input  WIDTH  operand A, latched on start.
- b_in  input  WIDTH  operand B, latched on start.
- first_sel  input  SEL_W  first opcode, latched on start.
- last_sel  input  SEL_W  last opcode, latched on start.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_sel  output  SEL_W  opcode to the ALU.
- alu_en  output  1  ALU enable.
- alu_result  input  WIDTH  ALU result.
- res_valid  output  1  one-cycle pulse; res_sel and res_data are valid.
- res_sel  output  SEL_W  opcode of the captured result.
- res_data  output  WIDTH  captured result.
- signature  output  SIG_W  running result signature.
- busy  output  1  high from SETUP through DONE.
- done  output  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0. State IDLE, hold counter 0. Reset mid-sweep aborts immediately and emits no done.
- States: IDLE, SETUP, RUN, DONE. All outputs are registered.
- IDLE: alu_en=0 and busy=0. When start=1, latch a_in, b_in, first_sel, last_sel, set alu_sel<=first_sel and go to SETUP.
- SETUP (exactly 1 cycle): alu_a and alu_b are driven with the latched operands; alu_en=0; signature<=0; busy=1. Next state is RUN with hold_cnt=0.
- RUN: alu_en=1. hold_cnt increments every cycle.
- On the edge where hold_cnt==HOLD-1 (the capture edge):
  - res_data<=alu_result, res_sel<=alu_sel, res_valid<=1 for one cycle.
  - signature <= rotate_left_1(signature) XOR zero-extended alu_result.
  - If alu_sel==last_sel: go to DONE and set done<=1. alu_en stays 1 during this final res_valid/done cycle and goes 0 on the DONE→IDLE edge.
  - Otherwise: alu_sel<=alu_sel+1 (mod 2**SEL_W), hold_cnt<=0.
- Sweep length: N = ((last_sel-first_sel) mod 2**SEL_W) + 1.
  - first_sel==last_sel gives a single op.
  - last_sel<first_sel wraps through max→0.
  - first=0, last=15 gives all 16 ops.
- Timing: start sampled at edge t0. Capture k (k=1..N) occurs at edge t0+1+HOLD*k. The final res_valid and done are high together in the cycle after edge t0+1+HOLD*N.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE with alu_en=0 and done=0. signature, res_sel and res_data hold until the next start or rst.
- start while not in IDLE is ignored. start held high re-triggers a new sweep from IDLE on the cycle after DONE.
- alu_result is sampled only on capture edges. Its value at any other time has no effect.

Test Plan:
1. Reset, then start with a=4'b0010, b=4'b0100, first=0, last=15, HOLD=4, bench ALU returning a+b for every sel → alu_en low for 1 cycle, then high; 16 res_valid pulses with res_sel 0..15 in order and res_data=4'b0110 each; done coincides with pulse 16 at edge t0+65; busy falls the next cycle.
2. Bench ALU returning constant 4'hF, first=3, last=4 → res_valid pulses with res_sel 3 then 4; signature 8'h0F after the first capture and 8'h11 after the second.
3. Wrap-around: first=14, last=1 → res_sel sequence 14, 15, 0, 1; exactly 4 pulses; done with the 4th. Single op: first=last=7 → exactly one pulse, res_sel=7.
4. start pulsed during RUN and again during DONE with different a_in → ignored; alu_a unchanged; pulse count unchanged.
5. rst asserted after the 5th capture → next cycle all outputs 0, state IDLE, no done pulse. A new start then runs a full, correct sweep.
6. HOLD=1 build, first=0, last=15 → one capture per cycle; 16 consecutive res_valid cycles with res_sel incrementing; done at edge t0+17.
